// File: rtl/sort_sequencer.sv
// sort_sequencer: loads operands over a push port, drives the shared sorter, then streams sorted results.
// Optional macro SORT_SEQ_TIMEOUT_EN adds a sort-done timeout with a sticky error flag.
module sort_sequencer #(
  parameter int DATA_W       = 4,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 4,
  parameter int SORT_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    start,
  output logic                    busy,
  output logic                    sort_enable,
  output logic [DEPTH*DATA_W-1:0] unsorted_array,
  output logic [CNT_W-1:0]        count,
  input  logic [DEPTH*DATA_W-1:0] sorted_array,
  input  logic                    sort_done,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_count, w_count_nxt;
  logic [CNT_W-1:0]        r_idx, w_idx_nxt, w_idx_inc;
  logic [DEPTH*DATA_W-1:0] r_unsorted, w_unsorted_nxt;
  logic [DEPTH*DATA_W-1:0] r_buf, w_buf_nxt;
  logic                    r_sort_enable, w_sort_enable_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic                    r_out_last, w_out_last_nxt;
  logic [DATA_W-1:0]       r_out_data, w_out_data_nxt;
  logic                    r_error, w_error_nxt;
  logic                    w_in_ready;

`ifdef SORT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(SORT_TIMEOUT + 1);
  logic [TW-1:0] r_timer, w_timer_nxt;
`endif

  generate
    if (CNT_W < $clog2(DEPTH + 1) || SORT_TIMEOUT < 1) begin : g_bad_cfg
      $error("sort_sequencer: CNT_W cannot hold DEPTH or SORT_TIMEOUT < 1");
    end
  endgenerate

  // Slot k of a flattened array lives at bits [k*DATA_W +: DATA_W]; reads use slot DEPTH-1-idx.
  function automatic logic [DATA_W-1:0] slot_rd(input logic [DEPTH*DATA_W-1:0] arr,
                                                input logic [CNT_W-1:0]        idx);
    slot_rd = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1 - int'(idx)) slot_rd = arr[i*DATA_W +: DATA_W];
      else                            slot_rd = slot_rd;
    end
  endfunction

  function automatic logic [DEPTH*DATA_W-1:0] slot_wr(input logic [DEPTH*DATA_W-1:0] arr,
                                                      input logic [CNT_W-1:0]        idx,
                                                      input logic [DATA_W-1:0]       val);
    slot_wr = arr;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1 - int'(idx)) slot_wr[i*DATA_W +: DATA_W] = val;
      else                            slot_wr[i*DATA_W +: DATA_W] = arr[i*DATA_W +: DATA_W];
    end
  endfunction

  assign w_in_ready = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH));
  assign w_idx_inc  = r_idx + CNT_W'(1);

  // Next-state and next-output logic for the load / sort / drain sequence.
  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_idx_nxt         = r_idx;
    w_unsorted_nxt    = r_unsorted;
    w_buf_nxt         = r_buf;
    w_sort_enable_nxt = r_sort_enable;
    w_busy_nxt        = r_busy;
    w_out_valid_nxt   = r_out_valid;
    w_out_last_nxt    = r_out_last;
    w_out_data_nxt    = r_out_data;
    w_error_nxt       = r_error;
`ifdef SORT_SEQ_TIMEOUT_EN
    w_timer_nxt       = r_timer;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_in_ready) begin
          w_unsorted_nxt = slot_wr(r_unsorted, r_count, in_data);
          w_count_nxt    = r_count + CNT_W'(1);
        end else begin
          w_count_nxt    = r_count;
        end
        // The push above is folded in first so the sorter sees the updated count.
        if (start && (w_count_nxt != {CNT_W{1'b0}})) begin
          w_state_nxt       = S_SORT;
          w_sort_enable_nxt = 1'b1;
          w_busy_nxt        = 1'b1;
          w_error_nxt       = 1'b0;
`ifdef SORT_SEQ_TIMEOUT_EN
          w_timer_nxt       = {TW{1'b0}};
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SORT: begin
        if (sort_done) begin
          w_buf_nxt         = sorted_array;
          w_sort_enable_nxt = 1'b0;
          w_state_nxt       = S_DRAIN;
          w_idx_nxt         = {CNT_W{1'b0}};
          w_out_valid_nxt   = 1'b1;
          w_out_data_nxt    = slot_rd(sorted_array, {CNT_W{1'b0}});
          w_out_last_nxt    = (r_count == CNT_W'(1));
        end
`ifdef SORT_SEQ_TIMEOUT_EN
        else if (r_timer == TW'(SORT_TIMEOUT - 1)) begin
          w_state_nxt       = S_IDLE;
          w_sort_enable_nxt = 1'b0;
          w_busy_nxt        = 1'b0;
          w_error_nxt       = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
`else
        else begin
          w_state_nxt = S_SORT;
        end
`endif
      end
      S_DRAIN: begin
        if (r_out_valid && out_ready) begin
          if (r_out_last) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_out_data_nxt  = {DATA_W{1'b0}};
            w_count_nxt     = {CNT_W{1'b0}};
            w_unsorted_nxt  = {(DEPTH*DATA_W){1'b0}};
            w_busy_nxt      = 1'b0;
          end else begin
            w_idx_nxt      = w_idx_inc;
            w_out_data_nxt = slot_rd(r_buf, w_idx_inc);
            w_out_last_nxt = (w_idx_inc == (r_count - CNT_W'(1)));
          end
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= {CNT_W{1'b0}};
      r_idx         <= {CNT_W{1'b0}};
      r_unsorted    <= {(DEPTH*DATA_W){1'b0}};
      r_buf         <= {(DEPTH*DATA_W){1'b0}};
      r_sort_enable <= 1'b0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= {DATA_W{1'b0}};
      r_error       <= 1'b0;
`ifdef SORT_SEQ_TIMEOUT_EN
      r_timer       <= {TW{1'b0}};
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_idx         <= w_idx_nxt;
      r_unsorted    <= w_unsorted_nxt;
      r_buf         <= w_buf_nxt;
      r_sort_enable <= w_sort_enable_nxt;
      r_busy        <= w_busy_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_last    <= w_out_last_nxt;
      r_out_data    <= w_out_data_nxt;
      r_error       <= w_error_nxt;
`ifdef SORT_SEQ_TIMEOUT_EN
      r_timer       <= w_timer_nxt;
`endif
    end
  end

  assign in_ready       = w_in_ready;
  assign busy           = r_busy;
  assign sort_enable    = r_sort_enable;
  assign unsorted_array = r_unsorted;
  assign count          = r_count;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign error          = r_error;

endmodule

// File: tb/tb_sort_sequencer.sv
// Randomized self-checking bench for sort_sequencer; the bench also plays the sorter.
module tb_sort_sequencer;
  localparam int W = 4;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready;
  logic           start = 1'b0;
  logic           busy;
  logic           sort_enable;
  logic [D*W-1:0] unsorted_array;
  logic [3:0]     count;
  logic [D*W-1:0] sorted_array = '0;
  logic           sort_done = 1'b0;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b0;
  logic           out_last;
  logic           error;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: operands in push order plus the expected flattened operand array.
  logic [W-1:0]   mq[$];
  logic [D*W-1:0] m_uns;

  always #5 clk = ~clk;

  sort_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .busy(busy), .sort_enable(sort_enable), .unsorted_array(unsorted_array),
    .count(count), .sorted_array(sorted_array), .sort_done(sort_done), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .out_last(out_last), .error(error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    mq.delete();
    m_uns = '0;
  endtask

  task automatic m_push(input logic [W-1:0] v);
    if (mq.size() < D) begin
      m_uns[(D-1-mq.size())*W +: W] = v;
      mq.push_back(v);
    end
  endtask

  task automatic chk_reset();
    chk("rst_outs", {busy, sort_enable, out_valid, out_last, error, in_ready}, 6'b000001);
    chk("rst_count", count, 0);
    chk("rst_uns", unsorted_array, 0);
    chk("rst_data", out_data, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0; sort_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset();
    m_clear();
  endtask

  task automatic do_push(input logic [W-1:0] v);
    in_valid = 1'b1; in_data = v;
    chk("in_ready", in_ready, mq.size() < D);
    m_push(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a sort (optionally with a same-cycle push), act as sorter, then drain and check.
  task automatic do_sort(input int lat, input int pct, input bit push_too, input logic [W-1:0] pv,
                         input int stall_at, input int rst_at);
    logic [W-1:0]   s[$];
    logic [D*W-1:0] sa;
    int n, k, guard, stall_left;
    start = 1'b1;
    if (push_too) begin
      in_valid = 1'b1; in_data = pv;
      m_push(pv);
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    n = mq.size();
    if (n == 0) begin
      chk("empty_start", {sort_enable, busy}, 2'b00);
      return;
    end
    chk("sort_entry", {sort_enable, busy, in_ready, out_valid, error}, 5'b11000);
    chk("sort_count", count, n);
    chk("sort_uns", unsorted_array, m_uns);
    for (int c = 1; c < lat; c++) begin
      in_valid = 1'b1; in_data = 4'hA; start = 1'b1; sort_done = 1'b0;
      @(negedge clk);
      chk("sort_hold", {sort_enable, busy, in_ready, count}, {3'b110, 4'(n)});
    end
    in_valid = 1'b0; start = 1'b0;
    s = mq; s.sort();
    sa = {$urandom, $urandom};
    for (int i = 0; i < n; i++) sa[(D-1-i)*W +: W] = s[i];
    sorted_array = sa; sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0; sorted_array = {$urandom, $urandom};
    chk("drain_entry", {sort_enable, busy, out_valid}, 3'b011);
    k = 0; guard = 0; stall_left = 5;
    while (k < n && guard < 400) begin
      if (k == rst_at) begin
        rst_n = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset();
        m_clear();
        return;
      end
      if (k == stall_at && stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else begin
        out_ready = ($urandom_range(99, 0) < pct);
      end
      start = $urandom_range(1, 0);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, s[k]);
      chk("out_last", out_last, k == n - 1);
      @(negedge clk);
      if (out_ready) k++;
      guard++;
    end
    out_ready = 1'b0; start = 1'b0;
    chk("drain_len", k, n);
    chk("done_state", {out_valid, busy, sort_enable, in_ready, count}, {4'b0001, 4'd0});
    chk("done_uns", unsorted_array, 0);
    m_clear();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Basic five-operand sort with 10-cycle sorter latency.
    do_push(4'd6); do_push(4'd4); do_push(4'd2); do_push(4'd7); do_push(4'd15);
    chk("uns_slots", unsorted_array[31:12], 20'h6427F);
    do_sort(10, 100, 1'b0, '0, -1, -1);

    // Overfill: ninth push refused.
    for (int v = 1; v <= 9; v++) do_push(4'(v));
    chk("full_count", count, 8);
    chk("full_ready", in_ready, 0);
    do_sort(3, 100, 1'b0, '0, -1, -1);

    // Empty start ignored; push and start in the same cycle.
    do_sort(2, 100, 1'b0, '0, -1, -1);
    do_sort(2, 100, 1'b1, 4'd3, -1, -1);

    // Back-pressure for 5 cycles on the 3rd element.
    do_push(4'd9); do_push(4'd1); do_push(4'd12); do_push(4'd5); do_push(4'd0);
    do_sort(4, 100, 1'b0, '0, 2, -1);

    // Reset mid-drain after the first output, then reload.
    do_push(4'd11); do_push(4'd2); do_push(4'd8);
    do_sort(3, 100, 1'b0, '0, -1, 1);
    do_push(4'd5);
    chk("rst_reload_uns", unsorted_array, m_uns);
    chk("rst_reload_cnt", count, 1);
    do_sort(2, 100, 1'b0, '0, -1, -1);

`ifdef SORT_SEQ_TIMEOUT_EN
    begin
      int cyc;
      do_push(4'd13); do_push(4'd7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (sort_enable && cyc < 200) begin
        cyc++;
        @(negedge clk);
      end
      chk("to_cycles", cyc, 64);
      chk("to_state", {error, sort_enable, busy, in_ready}, 4'b1001);
      chk("to_count", count, 2);
      chk("to_uns", unsorted_array, m_uns);
      do_sort(5, 80, 1'b0, '0, -1, -1);
      chk("to_err_sticky_clr", error, 0);
    end
`endif

    // Randomized transactions with stray sort_done in idle.
    for (int it = 0; it < 25; it++) begin
      int np;
      sort_done = 1'b1;
      @(negedge clk);
      sort_done = 1'b0;
      chk("stray_done", {busy, sort_enable, out_valid}, 3'b000);
      np = $urandom_range(10, 0);
      for (int j = 0; j < np; j++) do_push(4'($urandom_range(15, 0)));
      chk("rand_count", count, mq.size());
      chk("rand_uns", unsorted_array, m_uns);
      do_sort($urandom_range(12, 1), 60, $urandom_range(1, 0), 4'($urandom_range(15, 0)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
